// File: rtl/opt_scheduler_if.sv
// Bundle of signals between the replica requesters / route datapath and the
// optimisation-pass scheduler.
// master: requester + datapath side; slave: the scheduler.
interface opt_scheduler_if #(
  parameter int NREQ = 4
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [2*NREQ-1:0] req_cmd;
  logic [7*NREQ-1:0] req_k;
  logic [7*NREQ-1:0] req_l;
  logic [NREQ-1:0]   req_ready;
  logic              cmd_valid;
  logic [1:0]        cmd_code;
  logic [6:0]        cmd_k;
  logic [6:0]        cmd_l;
  logic [OW-1:0]     cmd_owner;
  logic              dp_beat;
  logic              busy;
  logic              done;
  logic [OW-1:0]     done_owner;
  logic              err;

  modport master (
    output req_valid, req_cmd, req_k, req_l, dp_beat,
    input  req_ready, cmd_valid, cmd_code, cmd_k, cmd_l, cmd_owner,
           busy, done, done_owner, err
  );

  modport slave (
    input  req_valid, req_cmd, req_k, req_l, dp_beat,
    output req_ready, cmd_valid, cmd_code, cmd_k, cmd_l, cmd_owner,
           busy, done, done_owner, err
  );
endinterface

// File: rtl/opt_scheduler.sv
// Round-robin scheduler that hands route-optimisation passes from NREQ
// replicas to a single route datapath and times the pass to completion.
// Optional build macro OPT_SCHED_CHECK_EN: rejects OR0/OR1 commands whose
// K/L indices are out of order or beyond the route (ack + err, no issue).
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the winner
// ISSUE | one-cycle start pulse to the datapath
// RUN   | counting datapath beats until WORDS have arrived
// DRAIN | GAP idle cycles, then done on the last DRAIN cycle
module opt_scheduler #(
  parameter int NREQ  = 4,
  parameter int WORDS = 4,
  parameter int GAP   = 2
) (
  input logic            clk,
  input logic            reset,
  opt_scheduler_if.slave bus
);
  localparam int OW = $clog2(NREQ);
  localparam int BW = $clog2(WORDS + 1);
  // GAP+2 keeps the counter at least one bit wide when GAP is 0.
  localparam int GW = $clog2(GAP + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] last_grant;
  logic [BW-1:0] beat_cnt;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    code_q;
  logic [6:0]    k_q, l_q;
  logic [OW-1:0] owner_q;

  logic          found;
  logic [OW-1:0] winner;
  logic [1:0]    w_cmd;
  logic [6:0]    w_k, w_l;
  logic          grant;
  logic          bad;

  // Round-robin search starting one past the last granted replica.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && bus.req_valid[(int'(last_grant) + i) % NREQ] &&
          bus.req_cmd[((int'(last_grant) + i) % NREQ) * 2 +: 2] != 2'd0) begin
        found  = 1'b1;
        winner = OW'((int'(last_grant) + i) % NREQ);
      end
    end
  end

  assign w_cmd = bus.req_cmd[int'(winner) * 2 +: 2];
  assign w_k   = bus.req_k[int'(winner) * 7 +: 7];
  assign w_l   = bus.req_l[int'(winner) * 7 +: 7];

`ifdef OPT_SCHED_CHECK_EN
  // Only OR0/OR1 carry a city range; K must precede L and L must lie on the route.
  assign bad     = w_cmd[1] && ((w_k >= w_l) || (int'(w_l) >= WORDS * 8));
  assign bus.err = grant & bad;
`else
  assign bad     = 1'b0;
  assign bus.err = 1'b0;
`endif

  // Next-state logic; grant is only ever raised from IDLE, so it cannot
  // coincide with done (which is produced in DRAIN).
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !reset) begin
          grant = 1'b1;
          if (!bad) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.dp_beat && WORDS == 1) state_d = DRAIN;
        else                           state_d = RUN;
      end
      RUN: begin
        if (bus.dp_beat && beat_cnt == BW'(WORDS - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (gap_cnt == GW'(GAP)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, arbitration history, counters and latched command fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_grant <= OW'(NREQ - 1);
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      code_q     <= '0;
      k_q        <= '0;
      l_q        <= '0;
      owner_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant) last_grant <= winner;
      if (grant && !bad) begin
        code_q  <= w_cmd;
        k_q     <= w_k;
        l_q     <= w_l;
        owner_q <= winner;
      end
      if (state_q == ISSUE)                beat_cnt <= bus.dp_beat ? BW'(1) : '0;
      else if (state_q == RUN && bus.dp_beat) beat_cnt <= beat_cnt + BW'(1);
      gap_cnt <= (state_q == DRAIN) ? gap_cnt + GW'(1) : '0;
    end
  end

  assign bus.req_ready  = grant ? (NREQ'(1) << winner) : '0;
  assign bus.cmd_valid  = (state_q == ISSUE) && !reset;
  assign bus.done       = (state_q == DRAIN) && (gap_cnt == GW'(GAP)) && !reset;
  assign bus.busy       = (state_q != IDLE);
  assign bus.cmd_code   = code_q;
  assign bus.cmd_k      = k_q;
  assign bus.cmd_l      = l_q;
  assign bus.cmd_owner  = owner_q;
  assign bus.done_owner = owner_q;
endmodule

// File: tb/tb_opt_scheduler.sv
// Directed bench for opt_scheduler: default build (GAP=2) plus a GAP=0 copy.
module tb_opt_scheduler;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  opt_scheduler_if #(.NREQ(4)) bus ();
  opt_scheduler_if #(.NREQ(4)) bus0 ();

  opt_scheduler #(.NREQ(4), .WORDS(4), .GAP(2)) dut  (.clk(clk), .reset(reset), .bus(bus));
  opt_scheduler #(.NREQ(4), .WORDS(4), .GAP(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_valid  = '0; bus.req_cmd  = '0; bus.req_k  = '0; bus.req_l  = '0; bus.dp_beat  = 1'b0;
    bus0.req_valid = '0; bus0.req_cmd = '0; bus0.req_k = '0; bus0.req_l = '0; bus0.dp_beat = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [1:0] c, input logic [6:0] k, input logic [6:0] l);
    bus.req_valid[i]    = 1'b1;
    bus.req_cmd[i*2 +: 2] = c;
    bus.req_k[i*7 +: 7]   = k;
    bus.req_l[i*7 +: 7]   = l;
  endtask

  task automatic do_reset();
    clear_reqs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_reqs();
    reset = 1'b1;
    step();
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0000 || bus.cmd_valid !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b cmd_valid=%b done=%b err=%b, required 0000/0/0/0",
               bus.req_ready, bus.cmd_valid, bus.done, bus.err);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.cmd_owner !== 2'd0 || bus.cmd_code !== 2'd0 ||
        bus.cmd_k !== 7'd0 || bus.done_owner !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b owner=%0d code=%0d k=%0d done_owner=%0d, required all 0",
               bus.busy, bus.cmd_owner, bus.cmd_code, bus.cmd_k, bus.done_owner);
    end
  endtask

  task automatic test_single_pass();
    step();
    set_req(0, 2'd2, 7'd3, 7'd17);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_grant: req_ready=%b, required 0001", bus.req_ready);
    end
    step();
    clear_reqs();
    @(negedge clk);
    n_checks++;
    if (bus.cmd_valid !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL single_issue: cmd_valid=%b busy=%b, required 1/1", bus.cmd_valid, bus.busy);
    end
    n_checks++;
    if (bus.cmd_code !== 2'd2 || bus.cmd_k !== 7'd3 || bus.cmd_l !== 7'd17 || bus.cmd_owner !== 2'd0) begin
      n_fail++;
      $display("FAIL single_fields: code=%0d k=%0d l=%0d owner=%0d, required 2/3/17/0",
               bus.cmd_code, bus.cmd_k, bus.cmd_l, bus.cmd_owner);
    end
    step();
    bus.dp_beat = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_pulse_width: cmd_valid=%b in RUN, required 0", bus.cmd_valid);
    end
    step(); step(); step();
    step();
    bus.dp_beat = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL single_done_early1: done=%b at beat+1, required 0", bus.done);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL single_done_early2: done=%b at beat+2, required 0", bus.done);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.done_owner !== 2'd0) begin
      n_fail++; $display("FAIL single_done: done=%b owner=%0d at beat+3, required 1/0", bus.done, bus.done_owner);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_after_done: done=%b busy=%b, required 0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    int order[5];
    int exp_order[5];
    int ng;
    int viol;
    int multi;
    exp_order = '{0, 1, 2, 3, 0};
    ng = 0; viol = 0; multi = 0;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 2'd1, 7'(10 + i), 7'(20 + i));
    bus.dp_beat = 1'b1;
    for (int cyc = 0; cyc < 200 && ng < 5; cyc++) begin
      @(negedge clk);
      if (bus.req_ready != 4'b0000) begin
        if (bus.busy) viol++;
        if ($countones(bus.req_ready) != 1) multi++;
        for (int b = 0; b < 4; b++) if (bus.req_ready[b]) order[ng] = b;
        ng++;
      end
      step();
    end
    clear_reqs();
    n_checks++;
    if (ng !== 5) begin
      n_fail++; $display("FAIL rr_timeout: saw %0d grants, required 5", ng);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < ng) begin
        n_checks++;
        if (order[i] !== exp_order[i]) begin
          n_fail++; $display("FAIL rr_order[%0d]: granted %0d, required %0d", i, order[i], exp_order[i]);
        end
      end
    end
    n_checks++;
    if (viol !== 0 || multi !== 0) begin
      n_fail++; $display("FAIL rr_busy_grant: %0d grants while busy, %0d non-one-hot, required 0/0", viol, multi);
    end
  endtask

  task automatic test_issue_beat();
    do_reset();
    set_req(2, 2'd3, 7'd4, 7'd9);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL ib_grant: req_ready=%b, required 0100", bus.req_ready);
    end
    step();
    clear_reqs();
    bus.dp_beat = 1'b1;
    step(); step();
    step();
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL ib_run3: busy=%b done=%b on 3rd RUN beat, required 1/0", bus.busy, bus.done);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL ib_drain1: done=%b, required 0", bus.done);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL ib_drain2: done=%b, required 0", bus.done);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.done_owner !== 2'd2) begin
      n_fail++; $display("FAIL ib_done: done=%b owner=%0d, required 1/2", bus.done, bus.done_owner);
    end
    step();
    bus.dp_beat = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL ib_idle: busy=%b after done, required 0", bus.busy);
    end
  endtask

  task automatic test_cmd_zero();
    do_reset();
    bus.req_valid[1] = 1'b1;
    set_req(2, 2'd1, 7'd0, 7'd0);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL cmd_zero_skip: req_ready=%b, required 0100", bus.req_ready);
    end
    step();
    clear_reqs();
  endtask

  task automatic test_reset_mid_run();
    int seen_done;
    seen_done = 0;
    do_reset();
    set_req(1, 2'd1, 7'd2, 7'd3);
    step();
    clear_reqs();
    step();
    bus.dp_beat = 1'b1;
    step();
    step();
    bus.dp_beat = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_run_busy: busy=%b after reset, required 0", bus.busy);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.done) seen_done++;
      step();
    end
    n_checks++;
    if (seen_done !== 0) begin
      n_fail++; $display("FAIL rst_run_done: %0d done pulses after reset, required 0", seen_done);
    end
    for (int i = 0; i < 4; i++) set_req(i, 2'd1, 7'd1, 7'd2);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rst_run_regrant: req_ready=%b, required 0001", bus.req_ready);
    end
    step();
    clear_reqs();
  endtask

  task automatic test_check();
    do_reset();
    set_req(0, 2'd3, 7'd20, 7'd5);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL chk_ack: req_ready=%b, required 0001", bus.req_ready);
    end
`ifdef OPT_SCHED_CHECK_EN
    n_checks++;
    if (bus.err !== 1'b1) begin
      n_fail++; $display("FAIL chk_err: err=%b, required 1", bus.err);
    end
    step();
    clear_reqs();
    @(negedge clk);
    n_checks++;
    if (bus.cmd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL chk_no_issue: cmd_valid=%b busy=%b err=%b, required 0/0/0",
                         bus.cmd_valid, bus.busy, bus.err);
    end
`else
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++; $display("FAIL chk_err_tied: err=%b, required 0", bus.err);
    end
    step();
    clear_reqs();
    @(negedge clk);
    n_checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 2'd3 || bus.cmd_k !== 7'd20 || bus.cmd_l !== 7'd5) begin
      n_fail++; $display("FAIL chk_issue: cmd_valid=%b code=%0d k=%0d l=%0d, required 1/3/20/5",
                         bus.cmd_valid, bus.cmd_code, bus.cmd_k, bus.cmd_l);
    end
`endif
    step();
  endtask

  task automatic test_gap0();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus0.req_valid[i]     = 1'b1;
      bus0.req_cmd[i*2 +: 2] = 2'd1;
      bus0.req_k[i*7 +: 7]   = 7'(i);
      bus0.req_l[i*7 +: 7]   = 7'(i + 8);
    end
    @(negedge clk);
    n_checks++;
    if (bus0.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL gap0_grant: req_ready=%b, required 0001", bus0.req_ready);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (bus0.cmd_valid !== 1'b1 || bus0.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL gap0_issue: cmd_valid=%b ready=%b, required 1/0000", bus0.cmd_valid, bus0.req_ready);
    end
    step();
    bus0.dp_beat = 1'b1;
    step(); step(); step();
    step();
    bus0.dp_beat = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus0.done !== 1'b1 || bus0.done_owner !== 2'd0 || bus0.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL gap0_done: done=%b owner=%0d ready=%b, required 1/0/0000",
                         bus0.done, bus0.done_owner, bus0.req_ready);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (bus0.req_ready !== 4'b0010 || bus0.done !== 1'b0) begin
      n_fail++; $display("FAIL gap0_regrant: ready=%b done=%b, required 0010/0", bus0.req_ready, bus0.done);
    end
    step();
    clear_reqs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clear_reqs();
    test_reset();
    test_single_pass();
    test_round_robin();
    test_issue_beat();
    test_cmd_zero();
    test_reset_mid_run();
    test_check();
    test_gap0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/opt_scheduler.md
OPT_SCHEDULER -- requirements
Module: opt_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of replica requesters (2..16).
REQ-002 Parameter WORDS, default 4, route words (8 cities each) per optimisation pass.
REQ-003 Parameter GAP, default 2, idle cycles between pass completion and done.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-replica optimisation request.
REQ-007 req_cmd  input  NREQx2  per-replica command: 1=THR, 2=OR0, 3=OR1; 0 reserved.
REQ-008 req_k, req_l  input  NREQx7 each  per-replica K and L city indices.
REQ-009 req_ready  output  NREQ  one-hot grant/accept strobe.
REQ-010 cmd_valid  output  1  one-cycle start pulse to the route datapath.
REQ-011 cmd_code, cmd_k, cmd_l  output  2/7/7  latched command fields; stable from grant until done.
REQ-012 cmd_owner  output  clog2(NREQ)  index of the granted replica.
REQ-013 dp_beat  input  1  datapath output-valid beat.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pass-complete pulse; done_owner (clog2(NREQ)) is valid with it.
REQ-016 err  output  1  one-cycle parameter-error pulse (CHECK build only).

Function
REQ-017 FSM states IDLE, ISSUE, RUN, DRAIN.
REQ-018 IDLE: if any req_valid has a nonzero cmd, round-robin pick starting at last_grant+1 mod NREQ.
- Assert req_ready[winner] for that one cycle.
- Latch cmd_code, cmd_k, cmd_l and cmd_owner.
- Go to ISSUE.
REQ-019 A requester with req_cmd=0 is treated as not requesting; req_ready stays low for it.
REQ-020 ISSUE: cmd_valid=1 for exactly one cycle; clear beat counter; go to RUN.
REQ-021 RUN: each dp_beat increments the beat counter (width clog2(WORDS+1)). The beat that brings the count to WORDS goes to DRAIN.
REQ-022 A dp_beat coincident with cmd_valid in ISSUE counts toward the pass.
REQ-023 dp_beat in IDLE or DRAIN is ignored; it never affects the counters.
REQ-024 DRAIN counts GAP cycles. On the last one, done=1 and done_owner=cmd_owner, then return to IDLE.
- GAP=0: done is asserted in the cycle after the last beat.
REQ-025 last_grant updates only on grant; a requester is granted at most once per NREQ consecutive passes while others are pending.
REQ-026 No new grant while busy; pending req_valid held by requesters is served later.
REQ-027 done and a new grant never occur in the same cycle; earliest re-grant is the cycle after done.

Reset
REQ-028 Reset in any state forces IDLE within one cycle and clears the counters.
- last_grant resets to NREQ-1, so replica 0 wins first.
- req_ready, cmd_valid, done, err and busy reset to 0.
- cmd_code, cmd_k, cmd_l, cmd_owner and done_owner reset to 0.
REQ-029 Reset mid-RUN drops the pass silently; no done is produced.

Configuration
REQ-030 Macro OPT_SCHED_CHECK_EN.
- Defined: at grant, an OR0/OR1 with K>=L or L>=WORDS*8 is still acknowledged (req_ready=1), but it is not issued. err pulses for one cycle and the FSM stays IDLE.
- Undefined: no checking, err tied to 0, every command is issued.

Verification
REQ-031 Reset, then req_valid=0001 cmd=OR0 K=3 L=17 -> req_ready=0001 at T; cmd_valid at T+1; 4 beats; done at last beat+3 with done_owner=0.
REQ-032 All four requesting continuously -> grant order 0,1,2,3,0; no grant while busy=1.
REQ-033 dp_beat during ISSUE plus 3 in RUN -> DRAIN entered on the 3rd RUN beat; stray beats in DRAIN do not change done timing.
REQ-034 Reset asserted after 2 RUN beats -> busy=0 next cycle, no done; the next request is served from replica 0.
REQ-035 CHECK build, OR1 K=20 L=5 -> req_ready=1, err=1, no cmd_valid, busy stays 0.
REQ-036 GAP=0 build -> done in the cycle after the 4th beat; re-grant is possible one cycle later.
